// File: rtl/axi_cart_fetch_pkg.sv
// gb_axi_pkg: shared AXI response codes, fetch FSM states and cache-line geometry for axi_cart_fetch
package gb_axi_pkg;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B
    } cart_fetch_state_t;

    localparam int LINE_BYTES = 8;
    localparam int LINE_OFF_W = 3;

    function automatic logic [7:0] byte_sel(input logic [63:0] line, input logic [LINE_OFF_W-1:0] off);
        return line[{off, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/axi_cart_fetch_if.sv
// axi_cart_fetch_if: AXI4-Lite bus (32-bit address, 64-bit data) between the cartridge fetch bridge and the PS HP port
// Modports: master (bridge side, drives ar/aw/w valids and r/b readies), slave (memory side)
interface axi_cart_fetch_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_cart_fetch_line_cache.sv
// cart_line_cache: single 8-byte line store with tag/valid, hit compare, byte read-out and byte write-through
// Ports: clock/resetn (sync active-low), clr (drop line), fill/fill_tag/fill_data (load line),
//        upd/upd_off/upd_byte (patch one byte), tag_in/off_in (lookup), hit/rd_byte (lookup result)
module cart_line_cache
    import gb_axi_pkg::*;
#(
    parameter int TAG_W = 20
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  fill,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [63:0]           fill_data,
    input  logic                  upd,
    input  logic [LINE_OFF_W-1:0] upd_off,
    input  logic [7:0]            upd_byte,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic [LINE_OFF_W-1:0] off_in,
    output logic                  hit,
    output logic [7:0]            rd_byte
);
    logic             line_valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;

    assign hit     = line_valid && tag == tag_in;
    assign rd_byte = byte_sel(data, off_in);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            line_valid <= 1'b0;
            tag        <= '0;
            data       <= '0;
        end else begin
            if (fill) begin
                line_valid <= 1'b1;
                tag        <= fill_tag;
                data       <= fill_data;
            end
            if (upd)
                data[{upd_off, 3'b000} +: 8] <= upd_byte;
            // clearing wins so an invalidate on the fill edge leaves the line dropped
            if (clr)
                line_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/axi_cart_fetch.sv
// axi_cart_fetch: Game Boy cartridge byte bus to AXI4-Lite initiator with a one-line (8-byte) read cache
// Optional feature macro: CART_FETCH_WRITE_EN (writes become AXI writes with cache write-through;
//   otherwise writes are acknowledged and dropped).
// Ports: clock/resetn (sync active-low), base_addr (DDR image base, bits [2:0] ignored),
//        invalidate (drop cached line), req_* (byte request valid/ready), rsp_* (one-cycle completion),
//        axi (AXI4-Lite master toward the PS S_AXI HP port)
module axi_cart_fetch
    import gb_axi_pkg::*;
#(
    parameter int REQ_ADDR_W = 23,
    parameter int AXI_ADDR_W = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [AXI_ADDR_W-1:0] base_addr,
    input  logic                  invalidate,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_err,
    axi_cart_fetch_if.master      axi
);
    localparam int TAG_W = REQ_ADDR_W - LINE_OFF_W;
`ifdef CART_FETCH_WRITE_EN
    localparam cart_fetch_state_t WR_STATE = ST_AWW;
`else
    localparam cart_fetch_state_t WR_STATE = ST_IDLE;
`endif

    cart_fetch_state_t     state, state_n;
    logic [REQ_ADDR_W-1:0] addr_q;
    logic [AXI_ADDR_W-1:0] line_addr;
    logic                  no_cache, accept, cache_hit, hit, r_done, r_ok, aw_ok, w_ok, upd;
    logic [7:0]            hit_byte;
    logic                  unused_base;

    assign req_ready   = resetn && state == ST_IDLE;
    assign accept      = req_valid && req_ready;
    // an invalidate arriving with the request must force a refetch
    assign hit         = cache_hit && !invalidate;
    assign r_done      = state == ST_R && axi.rvalid;
    assign r_ok        = axi_resp_t'(axi.rresp) == OKAY;
    assign unused_base = ^base_addr[LINE_OFF_W-1:0];
    // modulo 2^AXI_ADDR_W sum of the aligned base and the aligned cartridge line offset
    assign line_addr   = {base_addr[AXI_ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}}
                       + {{(AXI_ADDR_W-REQ_ADDR_W){1'b0}}, addr_q[REQ_ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    assign axi.araddr  = line_addr;
    assign axi.awaddr  = line_addr;
    assign axi.arvalid = state == ST_AR;
    assign axi.rready  = state == ST_R;

`ifdef CART_FETCH_WRITE_EN
    logic [7:0] wdata_q;
    logic       aw_done, w_done;

    assign axi.awvalid = state == ST_AWW && !aw_done;
    assign axi.wvalid  = state == ST_AWW && !w_done;
    assign axi.wdata   = {LINE_BYTES{wdata_q}};
    assign axi.wstrb   = 8'b1 << addr_q[LINE_OFF_W-1:0];
    assign axi.bready  = state == ST_B;
    assign aw_ok       = aw_done || axi.awready;
    assign w_ok        = w_done || axi.wready;
    assign upd         = accept && req_write && hit;

    // address and data channels complete independently; each flag remembers its own handshake
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (accept)
                wdata_q <= req_wdata;
            aw_done <= state == ST_AWW && !(aw_ok && w_ok) && aw_ok;
            w_done  <= state == ST_AWW && !(aw_ok && w_ok) && w_ok;
        end
    end
`else
    logic unused_wr;

    assign axi.awvalid = 1'b0;
    assign axi.wvalid  = 1'b0;
    assign axi.wdata   = '0;
    assign axi.wstrb   = '0;
    assign axi.bready  = 1'b0;
    assign aw_ok       = 1'b0;
    assign w_ok        = 1'b0;
    assign upd         = 1'b0;
    assign unused_wr   = ^{axi.awready, axi.wready, axi.bresp};
`endif

    cart_line_cache #(.TAG_W(TAG_W)) u_cache (
        .clock     (clock),
        .resetn    (resetn),
        .clr       (invalidate || (r_done && !r_ok)),
        .fill      (r_done && r_ok && !no_cache && !invalidate),
        .fill_tag  (addr_q[REQ_ADDR_W-1:LINE_OFF_W]),
        .fill_data (axi.rdata),
        .upd       (upd),
        .upd_off   (req_addr[LINE_OFF_W-1:0]),
        .upd_byte  (req_wdata),
        .tag_in    (req_addr[REQ_ADDR_W-1:LINE_OFF_W]),
        .off_in    (req_addr[LINE_OFF_W-1:0]),
        .hit       (cache_hit),
        .rd_byte   (hit_byte)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = req_write ? WR_STATE : (hit ? ST_IDLE : ST_AR);
            ST_AR:   if (axi.arready) state_n = ST_R;
            ST_R:    if (axi.rvalid) state_n = ST_IDLE;
            ST_AWW:  if (aw_ok && w_ok) state_n = ST_B;
            ST_B:    if (axi.bvalid) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            no_cache  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            rsp_valid <= 1'b0;
            if (accept)
                addr_q <= req_addr;
            // an invalidate seen while the fetch is in flight keeps its data out of the cache
            no_cache <= (state == ST_AR || state == ST_R) && (no_cache || invalidate);
            if (accept && !req_write && hit) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= hit_byte;
                rsp_err   <= 1'b0;
            end
`ifndef CART_FETCH_WRITE_EN
            if (accept && req_write) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
`endif
            if (r_done) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= byte_sel(axi.rdata, addr_q[LINE_OFF_W-1:0]);
                rsp_err   <= !r_ok;
            end
`ifdef CART_FETCH_WRITE_EN
            if (state == ST_B && axi.bvalid) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
                rsp_err   <= axi_resp_t'(axi.bresp) != OKAY;
            end
`endif
        end
    end
endmodule
